// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : addsub_arbiter
// Brief   : Round-robin share of one 32-bit adder_subtracter between two clients
// Revision: 1.0
// ============================================================================
module addsub_arbiter #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_ans,
    output logic        resp0_carry,
    output logic        resp0_ovf,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_ans,
    output logic        resp1_carry,
    output logic        resp1_ovf,
    output logic [31:0] dp_opA,
    output logic [31:0] dp_opB,
    output logic [2:0]  dp_command,
    input  logic [31:0] dp_ans,
    input  logic        dp_carryout,
    input  logic        dp_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic              sub_q, sub_d;
    logic [31:0]       res_ans_q, res_ans_d;
    logic              res_carry_q, res_carry_d;
    logic              res_ovf_q, res_ovf_d;

    logic              w_grant;
    logic              w_accept;
    logic              w_resp_hs;

    // On a tie the requester that did not win last time gets the datapath.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_grant = ~last_grant_q;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign req0_ready  = (state_q == IDLE) && !w_grant && req0_valid;
    assign req1_ready  = (state_q == IDLE) &&  w_grant && req1_valid;
    assign w_accept    = req0_ready || req1_ready;

    assign resp0_valid = (state_q == RESP) && !owner_q;
    assign resp1_valid = (state_q == RESP) &&  owner_q;
    assign w_resp_hs   = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

    assign resp0_ans   = res_ans_q;
    assign resp0_carry = res_carry_q;
    assign resp0_ovf   = res_ovf_q;
    assign resp1_ans   = res_ans_q;
    assign resp1_carry = res_carry_q;
    assign resp1_ovf   = res_ovf_q;

    assign dp_opA      = opa_q;
    assign dp_opB      = opb_q;
    assign dp_command  = {2'b00, sub_q};
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        sub_d        = sub_q;
        res_ans_d    = res_ans_q;
        res_carry_d  = res_carry_q;
        res_ovf_d    = res_ovf_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    opa_d   = w_grant ? req1_a   : req0_a;
                    opb_d   = w_grant ? req1_b   : req0_b;
                    sub_d   = w_grant ? req1_sub : req0_sub;
                    owner_d = w_grant;
                    cnt_d   = C_CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // The ripple result is only trusted once the full settle window has elapsed.
                if (cnt_q == '0) begin
                    res_ans_d   = dp_ans;
                    res_carry_d = dp_carryout;
                    res_ovf_d   = dp_overflow;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (w_resp_hs) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            sub_q        <= 1'b0;
            res_ans_q    <= '0;
            res_carry_q  <= 1'b0;
            res_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            sub_q        <= sub_d;
            res_ans_q    <= res_ans_d;
            res_carry_q  <= res_carry_d;
            res_ovf_q    <= res_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_arbiter
// Brief   : Scoreboard bench for addsub_arbiter with a behavioural adder model
// Revision: 1.0
// ============================================================================
module tb_addsub_arbiter;

    localparam int C_SETTLE = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        q0_valid, q1_valid, q0_sub, q1_sub;
    logic [31:0] q0_a, q0_b, q1_a, q1_b;
    logic        rr0 = 1'b0;
    logic        rr1 = 1'b0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_ans, resp1_ans, dp_opA, dp_opB, dp_ans;
    logic        resp0_carry, resp1_carry, resp0_ovf, resp1_ovf;
    logic [2:0]  dp_command;
    logic        dp_carryout, dp_overflow, busy;

    int          checks = 0;
    int          failures = 0;
    int          n_issued = 0;
    int          n_resp = 0;
    int          cyc = 0;
    int          mode0 = 0;
    int          mode1 = 0;
    item_t       stim0[$];
    item_t       stim1[$];
    logic [33:0] exp0[$];
    logic [33:0] exp1[$];
    int          grant_log[$];

    always #5 clk = ~clk;

    addsub_arbiter #(.SETTLE_CYCLES(C_SETTLE), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(q0_valid), .req0_ready(req0_ready), .req0_a(q0_a), .req0_b(q0_b), .req0_sub(q0_sub),
        .req1_valid(q1_valid), .req1_ready(req1_ready), .req1_a(q1_a), .req1_b(q1_b), .req1_sub(q1_sub),
        .resp0_valid(resp0_valid), .resp0_ready(rr0), .resp0_ans(resp0_ans),
        .resp0_carry(resp0_carry), .resp0_ovf(resp0_ovf),
        .resp1_valid(resp1_valid), .resp1_ready(rr1), .resp1_ans(resp1_ans),
        .resp1_carry(resp1_carry), .resp1_ovf(resp1_ovf),
        .dp_opA(dp_opA), .dp_opB(dp_opB), .dp_command(dp_command),
        .dp_ans(dp_ans), .dp_carryout(dp_carryout), .dp_overflow(dp_overflow),
        .busy(busy)
    );

    // External adder_subtracter: two's-complement add of A and (optionally inverted) B.
    logic [31:0] w_bx;
    assign w_bx = dp_command[0] ? ~dp_opB : dp_opB;
    assign {dp_carryout, dp_ans} = {1'b0, dp_opA} + {1'b0, w_bx} + {32'd0, dp_command[0]};
    assign dp_overflow = (dp_opA[31] == w_bx[31]) && (dp_ans[31] != dp_opA[31]);

    // Reference result {ovf, carry, ans} from integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint sa = longint'(signed'(a));
        longint sb = longint'(signed'(b));
        longint ur, sr;
        logic   c, v;
        ur = sub ? (ua - ub) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        c  = sub ? (ua >= ub) : (ur >= 64'sd4294967296);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, c, ur[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t rnd_item();
        item_t it;
        logic [31:0] corners [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        it.a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        it.b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
        it.sub = 1'($urandom_range(0, 1));
        return it;
    endfunction

    // Response-ready drivers: 0 = low, 1 = high, 2 = random.
    always @(posedge clk) begin
        #1;
        rr0 = (mode0 == 2) ? 1'($urandom_range(0, 1)) : (mode0 == 1);
        rr1 = (mode1 == 2) ? 1'($urandom_range(0, 1)) : (mode1 == 1);
    end

    item_t it0, it1;
    bit    got0, got1;

    initial begin
        q0_valid = 0; q0_a = 0; q0_b = 0; q0_sub = 0;
        forever begin
            @(posedge clk);
            if (stim0.size() != 0) begin
                it0 = stim0.pop_front();
                #1; q0_valid = 1; q0_a = it0.a; q0_b = it0.b; q0_sub = it0.sub;
                got0 = 0;
                for (int k = 0; k < 400 && !got0; k++) begin
                    @(negedge clk);
                    if (req0_ready) got0 = 1;
                end
                if (got0) exp0.push_back(model(it0.a, it0.b, it0.sub));
                else check("req0_accept_timeout", 0, 1);
                @(posedge clk); #1; q0_valid = 0;
            end
        end
    end

    initial begin
        q1_valid = 0; q1_a = 0; q1_b = 0; q1_sub = 0;
        forever begin
            @(posedge clk);
            if (stim1.size() != 0) begin
                it1 = stim1.pop_front();
                #1; q1_valid = 1; q1_a = it1.a; q1_b = it1.b; q1_sub = it1.sub;
                got1 = 0;
                for (int k = 0; k < 400 && !got1; k++) begin
                    @(negedge clk);
                    if (req1_ready) got1 = 1;
                end
                if (got1) exp1.push_back(model(it1.a, it1.b, it1.sub));
                else check("req1_accept_timeout", 0, 1);
                @(posedge clk); #1; q1_valid = 0;
            end
        end
    end

    // Monitor: protocol, latency, launch, stability and scoreboard compares.
    logic        mv[2], mr[2], qv[2], qr[2], ms[2], qs[2], mc[2], mo[2];
    logic [31:0] ma[2], qa[2], qb[2];
    assign mv = '{resp0_valid, resp1_valid};
    assign mr = '{rr0, rr1};
    assign qv = '{q0_valid, q1_valid};
    assign qr = '{req0_ready, req1_ready};
    assign qs = '{q0_sub, q1_sub};
    assign qa = '{q0_a, q1_a};
    assign qb = '{q0_b, q1_b};
    assign ma = '{resp0_ans, resp1_ans};
    assign mc = '{resp0_carry, resp1_carry};
    assign mo = '{resp0_ovf, resp1_ovf};

    int          acc_cyc[2];
    bit          pend[2], chk_dp[2], stall[2], prev_v[2];
    logic [31:0] acc_a[2], acc_b[2], prev_ans[2];
    logic [33:0] e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                pend[n] = 0; chk_dp[n] = 0; stall[n] = 0; prev_v[n] = 0;
            end
        end else begin
            check("ready_exclusive", {req0_ready, req1_ready} == 2'b11, 0);
            check("ready_while_busy", busy && (req0_ready || req1_ready), 0);
            check("resp_exclusive", {resp0_valid, resp1_valid} == 2'b11, 0);
            for (int n = 0; n < 2; n++) begin
                if (chk_dp[n]) begin
                    check("dp_launch", {dp_opA, dp_opB}, {acc_a[n], acc_b[n]});
                    check("dp_command", 64'(dp_command), {61'd0, 2'b00, ms[n]});
                    chk_dp[n] = 0;
                end
                if (qv[n] && qr[n]) begin
                    acc_cyc[n] = cyc; acc_a[n] = qa[n]; acc_b[n] = qb[n]; ms[n] = qs[n];
                    chk_dp[n] = 1; pend[n] = 1;
                    grant_log.push_back(n);
                end
                if (stall[n]) begin
                    check("stall_hold", {mv[n], ma[n]}, {1'b1, prev_ans[n]});
                end
                if (mv[n] && !prev_v[n]) begin
                    check("resp_latency", cyc - acc_cyc[n], C_SETTLE + 1);
                    check("resp_owner", pend[n], 1);
                    pend[n] = 0;
                end
                if (mv[n] && mr[n]) begin
                    if (n == 0 && exp0.size() != 0) e = exp0.pop_front();
                    else if (n == 1 && exp1.size() != 0) e = exp1.pop_front();
                    else e = 'x;
                    check(n == 0 ? "resp0_result" : "resp1_result", {mo[n], mc[n], ma[n]}, e);
                    n_resp++;
                end
                prev_v[n]   = mv[n];
                stall[n]    = mv[n] && !mr[n];
                prev_ans[n] = ma[n];
            end
        end
    end

    task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic sub);
        item_t it;
        it.a = a; it.b = b; it.sub = sub;
        stim0.push_back(it); n_issued++;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic sub);
        item_t it;
        it.a = a; it.b = b; it.sub = sub;
        stim1.push_back(it); n_issued++;
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 4000 && n_resp < n_issued; k++) @(negedge clk);
        check("drain_timeout", n_resp >= n_issued, 1);
    endtask

    task automatic wait_sig(input int which);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (which == 0 && busy) break;
            if (which == 1 && resp0_valid) break;
        end
        check("wait_timeout", k < 200, 1);
    endtask

    task automatic check_idle_zero(input string name);
        check(name, {req0_ready, req1_ready, resp0_valid, resp1_valid, busy, dp_command}, 0);
        check({name, "_dp"}, {dp_opA, dp_opB}, 0);
        check({name, "_ans"}, {resp0_ans, resp0_carry, resp0_ovf}, 0);
    endtask

    task automatic reset_pulse(input string name);
        @(posedge clk); #2;
        reset = 1;
        #1;
        check_idle_zero(name);
        exp0.delete(); exp1.delete();
        n_issued = n_resp;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_zero("reset_state");
        reset = 0;
        mode0 = 1; mode1 = 1;
        // Tie from the first cycle after reset: req0, req1, req0.
        push0(32'd5, 32'd3, 1'b0);
        push0(32'h7FFF_FFFF, 32'd1, 1'b0);
        push1(32'd5, 32'd3, 1'b1);
        wait_done();
        check("grant_count", grant_log.size(), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            check("grant_order", grant_log[i], (i == 1) ? 1 : 0);
        push1(32'd3, 32'd5, 1'b1);
        push0(32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_done();
        // Backpressure: hold resp0 ready low while req1 waits.
        mode0 = 0;
        push0($urandom, $urandom, 1'b0);
        wait_sig(1);
        push1($urandom, $urandom, 1'b1);
        repeat (10) @(negedge clk);
        check("bp_req1_not_ready", req1_ready, 0);
        mode0 = 1;
        wait_done();
        // Randomised traffic with random response backpressure.
        mode0 = 2; mode1 = 2;
        for (int i = 0; i < 25; i++) begin
            stim0.push_back(rnd_item()); n_issued++;
            stim1.push_back(rnd_item()); n_issued++;
        end
        wait_done();
        // Reset while settling, then while a response is pending.
        mode0 = 0; mode1 = 1;
        push0($urandom, $urandom, 1'b1);
        wait_sig(0);
        reset_pulse("reset_in_settle");
        push0($urandom, $urandom, 1'b0);
        wait_sig(1);
        reset_pulse("reset_in_resp");
        repeat (3) @(negedge clk);
        check("no_resp_after_reset", {resp0_valid, resp1_valid, busy}, 0);
        mode0 = 1;
        grant_log.delete();
        push0($urandom, $urandom, 1'b0);
        push1($urandom, $urandom, 1'b1);
        wait_done();
        check("post_reset_tie", grant_log.size() > 0 ? grant_log[0] : -1, 0);
        check("all_responses", n_resp, n_issued);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
